// File: rtl/result_arbiter.sv
// result_arbiter: round-robin merge of N_UNITS execution-unit result streams
// onto one registered writeback port with a valid/ready handshake.
module result_arbiter #(
   parameter int N_UNITS = 4,
   parameter int WIDTH   = 64,
   parameter int SRC_W   = $clog2(N_UNITS)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_UNITS-1:0]            valid_i,
   output logic [N_UNITS-1:0]            ready_i,
   input  logic [N_UNITS-1:0][WIDTH-1:0] data_i,
   output logic                          valid_o,
   input  logic                          ready_o,
   output logic [WIDTH-1:0]              data_o,
   output logic [SRC_W-1:0]              src_o
);

   logic               valid_q, valid_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [SRC_W-1:0]   src_q, src_d;
   logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;

   logic               load_en_s;
   logic               found_s;
   logic               accept_s;
   logic [SRC_W-1:0]   grant_s;
   logic [SRC_W:0]     cand_s;
   logic [N_UNITS-1:0] grant_oh_s;

   // Output register can take a word when empty or when it drains this cycle.
   assign load_en_s = ~valid_q | ready_o;
   assign accept_s  = load_en_s & found_s;

   // Circular search for the first valid unit at or after rr_ptr.
   always_comb begin
      grant_s = rr_ptr_q;
      found_s = 1'b0;
      cand_s  = '0;
      for (int i = 0; i < N_UNITS; i++) begin
         // rr_ptr < N and i < N, so one conditional subtract gives the modulo.
         cand_s = {1'b0, rr_ptr_q} + (SRC_W+1)'(i);
         if (cand_s >= (SRC_W+1)'(N_UNITS)) begin
            cand_s = cand_s - (SRC_W+1)'(N_UNITS);
         end else begin
            cand_s = cand_s;
         end
         if (!found_s && valid_i[cand_s[SRC_W-1:0]]) begin
            found_s = 1'b1;
            grant_s = cand_s[SRC_W-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

   // Accept strobe: one-hot grant, gated by reset so nothing is taken while
   // the block is held in reset (the flops cannot capture then).
   always_comb begin
      grant_oh_s = N_UNITS'(1) << grant_s;
      ready_i    = grant_oh_s & {N_UNITS{accept_s & reset}};
   end

   // Next-state: load granted word, drain when empty-handed, else hold.
   always_comb begin
      valid_d  = valid_q;
      data_d   = data_q;
      src_d    = src_q;
      rr_ptr_d = rr_ptr_q;
      if (accept_s) begin
         valid_d = 1'b1;
         data_d  = data_i[grant_s];
         src_d   = grant_s;
         if (grant_s == SRC_W'(N_UNITS - 1)) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = grant_s + SRC_W'(1);
         end
      end else if (load_en_s) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q  <= 1'b0;
         data_q   <= '0;
         src_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         valid_q  <= valid_d;
         data_q   <= data_d;
         src_q    <= src_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign src_o   = src_q;

endmodule

// File: tb/tb_result_arbiter.sv
// Directed bench for result_arbiter (N_UNITS=4, WIDTH=64).
module tb_result_arbiter;

   logic              clk = 1'b0;
   logic              reset;
   logic [3:0]        valid_i;
   logic [3:0]        ready_i;
   logic [3:0][63:0]  data_i;
   logic              valid_o;
   logic              ready_o;
   logic [63:0]       data_o;
   logic [1:0]        src_o;

   int nvec = 0;
   int nmis = 0;
   logic [63:0] d [4];
   logic [3:0]  oh;
   int          exp_src;

   result_arbiter #(.N_UNITS(4), .WIDTH(64)) dut (
      .clk     (clk),
      .reset   (reset),
      .valid_i (valid_i),
      .ready_i (ready_i),
      .data_i  (data_i),
      .valid_o (valid_o),
      .ready_o (ready_o),
      .data_o  (data_o),
      .src_o   (src_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      d[0] = 64'h0123_4567_89AB_CDEF;
      d[1] = 64'hDEAD_BEEF_0000_0001;
      d[2] = 64'h0000_0000_0000_00A5;
      d[3] = 64'hFEDC_BA98_7654_3210;
      for (int k = 0; k < 4; k++) data_i[k] = d[k];
      reset   = 1'b0;
      ready_o = 1'b0;
      valid_i = 4'b1111;

      // Reset held 3 cycles with every unit valid
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 64'(valid_o), 64'd0);
      chk("rst_data",  data_o,       64'd0);
      chk("rst_src",   64'(src_o),   64'd0);
      chk("rst_ready", 64'(ready_i), 64'd0);
      chk("rst_ptr",   64'(dut.rr_ptr_q), 64'd0);

      // Release: first grant to unit 0
      reset = 1'b1;
      #1;
      chk("first_ready", 64'(ready_i), 64'b0001);
      tick();
      chk("first_valid", 64'(valid_o), 64'd1);
      chk("first_src",   64'(src_o),   64'd0);
      chk("first_data",  data_o,       d[0]);
      chk("first_ptr",   64'(dut.rr_ptr_q), 64'd1);
      chk("full_noready", 64'(ready_i), 64'd0);

      // Drain with nothing pending: valid drops, payload holds
      valid_i = 4'b0000;
      ready_o = 1'b1;
      tick();
      chk("drain_valid", 64'(valid_o), 64'd0);
      chk("drain_src",   64'(src_o),   64'd0);
      chk("drain_data",  data_o,       d[0]);
      chk("drain_ptr",   64'(dut.rr_ptr_q), 64'd1);

      // Single source: unit 2
      valid_i = 4'b0100;
      #1;
      chk("single_ready", 64'(ready_i), 64'b0100);
      tick();
      valid_i = 4'b0000;
      chk("single_valid", 64'(valid_o), 64'd1);
      chk("single_data",  data_o,       64'hA5);
      chk("single_src",   64'(src_o),   64'd2);
      chk("single_ptr",   64'(dut.rr_ptr_q), 64'd3);

      // Round robin, all valid, pointer starting at 3: 3,0,1,2,3,0,1,2
      valid_i = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         exp_src = (3 + i) % 4;
         oh = 4'b0001 << exp_src;
         #1;
         chk("rr_ready", 64'(ready_i), 64'(oh));
         tick();
         chk("rr_valid", 64'(valid_o), 64'd1);
         chk("rr_src",   64'(src_o),   64'(exp_src));
         chk("rr_data",  data_o,       d[exp_src]);
      end

      // Backpressure: output full, ready_o low for 5 cycles
      ready_o = 1'b0;
      valid_i = 4'b0011;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_ready", 64'(ready_i), 64'd0);
         chk("bp_valid", 64'(valid_o), 64'd1);
         chk("bp_src",   64'(src_o),   64'd2);
         chk("bp_data",  data_o,       d[2]);
         chk("bp_ptr",   64'(dut.rr_ptr_q), 64'd3);
      end

      // Release: drain and refill in the same cycle (ptr 3 wraps to unit 0)
      ready_o = 1'b1;
      #1;
      chk("refill_ready", 64'(ready_i), 64'b0001);
      tick();
      chk("refill_valid", 64'(valid_o), 64'd1);
      chk("refill_src",   64'(src_o),   64'd0);
      chk("refill_data",  data_o,       d[0]);
      chk("refill_ptr",   64'(dut.rr_ptr_q), 64'd1);
      chk("refill2_ready", 64'(ready_i), 64'b0010);
      tick();
      chk("refill2_src",  64'(src_o),   64'd1);
      chk("refill2_ptr",  64'(dut.rr_ptr_q), 64'd2);

      // Wrap: bring ptr to 3, then valid 1001 grants 3 then 0
      valid_i = 4'b0100;
      tick();
      chk("wrap_pre_ptr", 64'(dut.rr_ptr_q), 64'd3);
      valid_i = 4'b1001;
      #1;
      chk("wrap_ready3", 64'(ready_i), 64'b1000);
      tick();
      chk("wrap_src3",   64'(src_o),   64'd3);
      chk("wrap_ptr0",   64'(dut.rr_ptr_q), 64'd0);
      chk("wrap_ready0", 64'(ready_i), 64'b0001);
      tick();
      chk("wrap_src0",   64'(src_o),   64'd0);
      chk("wrap_ptr1",   64'(dut.rr_ptr_q), 64'd1);

      // Skip: ptr 3 with only unit 1 valid
      valid_i = 4'b0100;
      tick();
      chk("skip_pre_ptr", 64'(dut.rr_ptr_q), 64'd3);
      valid_i = 4'b0010;
      #1;
      chk("skip_ready", 64'(ready_i), 64'b0010);
      tick();
      valid_i = 4'b0100;
      chk("skip_valid", 64'(valid_o), 64'd1);
      chk("skip_src",   64'(src_o),   64'd1);
      chk("skip_data",  data_o,       d[1]);
      chk("skip_ptr",   64'(dut.rr_ptr_q), 64'd2);

      // Async reset between edges while valid_o is high
      #2;
      reset = 1'b0;
      #1;
      chk("arst_valid", 64'(valid_o), 64'd0);
      chk("arst_data",  data_o,       64'd0);
      chk("arst_src",   64'(src_o),   64'd0);
      chk("arst_ready", 64'(ready_i), 64'd0);
      tick();
      chk("arst_hold_ready", 64'(ready_i), 64'd0);
      chk("arst_ptr",        64'(dut.rr_ptr_q), 64'd0);
      chk("arst_hold_valid", 64'(valid_o), 64'd0);
      #2;
      reset = 1'b1;
      #1;
      chk("reoffer_ready", 64'(ready_i), 64'b0100);
      tick();
      chk("reoffer_valid", 64'(valid_o), 64'd1);
      chk("reoffer_src",   64'(src_o),   64'd2);
      chk("reoffer_data",  data_o,       64'hA5);
      chk("reoffer_ptr",   64'(dut.rr_ptr_q), 64'd3);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/result_arbiter.md
Name: result_arbiter

Overview:
- Round-robin arbiter merging the result streams of all execution units (load/store, ALU, branch, mul/div) onto the single writeback/commit bus.
- Sits directly downstream of each unit's result FIFO.
- Input k's valid_i/ready_i/data_i attach to that FIFO's valid_o/ready_o/data_o.
- One registered output stage with valid/ready handshake toward writeback.

Parameters:
- N_UNITS, 4, number of result producers; legal range 2..8.
- WIDTH, 64, width in bits of one RESULT word; set to the width of RESULT at instantiation.
- SRC_W, $clog2(N_UNITS), width of the source-index field.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- valid_i  input  N_UNITS  per-unit result valid.
- ready_i  output  N_UNITS  per-unit accept; high only for the granted unit in an accepting cycle.
- data_i  input  N_UNITS x WIDTH  per-unit RESULT word.
- valid_o  output  1  output register holds a result.
- ready_o  input  1  writeback accepts the result this cycle.
- data_o  output  WIDTH  registered RESULT word.
- src_o  output  SRC_W  index of the unit that produced data_o.

Behaviour:
Reset:
- reset low asynchronously clears valid_o, data_o, src_o and rr_ptr to 0.
- ready_i is combinational and is therefore all-zero while valid_o=0 and no valid_i is high.

Handshake:
- A transfer on input k occurs when valid_i[k] & ready_i[k] at the rising edge.
- An output transfer occurs when valid_o & ready_o.
- Producers may not withdraw valid_i or change data_i until the transfer completes.
- ready_i never depends combinationally on ready_o through data paths. ready_i uses only the load-enable term.

Load enable:
- load_en = ~valid_o | ready_o.
- The output register accepts a new word in any cycle with load_en=1. A simultaneous drain and refill is allowed, giving 1 result/cycle sustained.

Grant:
- Search valid_i starting at index rr_ptr, then rr_ptr+1, ... wrapping modulo N_UNITS.
- The first set bit is granted.
- ready_i = onehot(grant) & {N_UNITS{load_en & any_valid}}. At most one bit of ready_i is high.

On an accepted transfer from unit g:
- data_o <= data_i[g]
- src_o <= g
- valid_o <= 1
- rr_ptr <= (g+1) mod N_UNITS, which wraps from N_UNITS-1 to 0.

Hold and drain:
- With load_en=1 and no valid_i: valid_o <= 0, and data_o/src_o hold their values.
- With load_en=0: all state holds. rr_ptr does not advance without a transfer.

Latency and fairness:
- Latency is 1 cycle from the input transfer edge to valid_o.
- With k units continuously valid, each unit is granted exactly once every k accepted transfers.
- Worst-case wait is N_UNITS-1 transfers.

Reset mid-operation:
- The output result and pointer are discarded.
- No ready_i pulse occurs while reset is low.

Test Plan:
- Reset behaviour: hold reset low 3 cycles with valid_i=4'b1111 → valid_o=0, data_o=0, src_o=0, ready_i=0. After release, the first grant goes to unit 0.
- Single source: valid_i=4'b0100, data_i[2]=64'hA5, ready_o=1 → ready_i=4'b0100. Next cycle valid_o=1, data_o=64'hA5, src_o=2, rr_ptr=3.
- Round-robin fairness: all four valid continuously, ready_o=1 → src_o sequence 0,1,2,3,0,1,... with one transfer per cycle and no gaps.
- Backpressure: output full, ready_o=0 for 5 cycles with valid_i=4'b0011 → ready_i=0, data_o/src_o stable, rr_ptr unchanged. When ready_o rises, the drain and refill happen in the same cycle.
- Wrap and skip: rr_ptr=3, valid_i=4'b1001 → unit 3 granted, then unit 0. With valid_i=4'b0010 and rr_ptr=3 → unit 1 granted and rr_ptr becomes 2.
- Async reset mid-stream: assert reset between clock edges while valid_o=1 → valid_o falls immediately. No transfer is counted and unit data is re-offered after release.
